// File: rtl/regfile.sv
// regfile: 32x32 register file, two combinational read ports, one write port, entry 0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.  Rev 1.0
`default_nettype none

module regfile_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

module regfile #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  input  logic [AWIDTH-1:0] rs_num,
  input  logic [AWIDTH-1:0] rt_num,
  input  logic [AWIDTH-1:0] rd_num,
  input  logic [WIDTH-1:0]  rd_data,
  input  logic              rd_we
);

  logic [DEPTH-1:0] en;
  logic [WIDTH-1:0] q [DEPTH];

  // Entry 0 is never written, so its register holds its reset value of zero.
  assign en[0] = 1'b0;

  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_dec
      assign en[i] = rd_we && (rd_num == AWIDTH'(i));
    end
    for (i = 0; i < DEPTH; i++) begin : g_entry
      regfile_reg #(.WIDTH(WIDTH)) u_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (en[i]),
        .d      (rd_data),
        .q      (q[i])
      );
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok  = rd_we && (rd_num != '0) && !reset;
  assign rs_data = (fwd_ok && (rd_num == rs_num)) ? rd_data : q[rs_num];
  assign rt_data = (fwd_ok && (rd_num == rt_num)) ? rd_data : q[rt_num];
`else
  assign rs_data = q[rs_num];
  assign rt_data = q[rt_num];
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// tb_regfile: directed checks of reset, write/read, entry 0, port independence, async reset and same-cycle access.
`default_nettype none

module tb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic        rd_we;

  int checks = 0;
  int errors = 0;

  regfile #(.WIDTH(32), .DEPTH(32), .AWIDTH(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .rs_num  (rs_num),
    .rt_num  (rt_num),
    .rd_num  (rd_num),
    .rd_data (rd_data),
    .rd_we   (rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic write(input logic [4:0] num, input logic [31:0] data);
    @(negedge clk);
    rd_we = 1'b1; rd_num = num; rd_data = data;
    @(negedge clk);
    rd_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_we = 1'b0; rd_num = '0; rd_data = '0; rs_num = 5'd0; rt_num = 5'd0;
    #2;
    check("reset_hold_rs", rs_data, 32'd0);
    check("reset_hold_rt", rt_data, 32'd0);
    #10 reset = 1'b0;

    // 1. every entry reads zero after reset
    for (int a = 0; a < 32; a++) begin
      rs_num = 5'(a);
      #1;
      check($sformatf("reset_sweep_r%0d", a), rs_data, 32'd0);
    end

    // 2. write then read, then a disabled write
    write(5'd5, 32'd88);
    rs_num = 5'd5; rt_num = 5'd5;
    #1;
    check("wr_r5_rs", rs_data, 32'd88);
    check("wr_r5_rt", rt_data, 32'd88);
    rd_we = 1'b0; rd_num = 5'd5; rd_data = 32'd89;
    @(negedge clk); #1;
    check("no_we_r5", rs_data, 32'd88);

    // 3. entry zero ignores writes, including same-cycle forwarding
    @(negedge clk);
    rd_we = 1'b1; rd_num = 5'd0; rd_data = 32'hDEADBEEF; rs_num = 5'd0; rt_num = 5'd0;
    #1;
    check("r0_same_cycle", rs_data, 32'd0);
    @(negedge clk);
    rd_we = 1'b0;
    #1;
    check("r0_rs", rs_data, 32'd0);
    check("r0_rt", rt_data, 32'd0);

    // 4. independent ports, no aliasing
    write(5'd1, 32'd20);
    write(5'd31, 32'd15);
    rs_num = 5'd1; rt_num = 5'd31;
    #1;
    check("r1_rs", rs_data, 32'd20);
    check("r31_rt", rt_data, 32'd15);
    rs_num = 5'd2; rt_num = 5'd5;
    #1;
    check("r2_untouched", rs_data, 32'd0);
    check("r5_kept", rt_data, 32'd88);

    // 5. asynchronous reset between edges overrides a pending write
    write(5'd7, 32'd28);
    rs_num = 5'd7; rt_num = 5'd7;
    #1;
    check("r7_written", rs_data, 32'd28);
    @(posedge clk);
    #7 reset = 1'b1;
    rd_we = 1'b1; rd_num = 5'd7; rd_data = 32'd99;
    #1;
    check("r7_async_clear", rs_data, 32'd0);
    @(posedge clk); #1;
    check("r7_write_in_reset", rs_data, 32'd0);
    @(negedge clk);
    reset = 1'b0; rd_we = 1'b0;
    @(negedge clk); #1;
    check("r7_after_release", rs_data, 32'd0);
    rt_num = 5'd5;
    #1;
    check("r5_cleared", rt_data, 32'd0);

    // write presented at the first edge after release is committed
    @(negedge clk);
    reset = 1'b1;
    #1;
    rd_we = 1'b1; rd_num = 5'd9; rd_data = 32'h0000_0055;
    #1 reset = 1'b0;
    @(negedge clk);
    rd_we = 1'b0; rs_num = 5'd9;
    #1;
    check("r9_after_release", rs_data, 32'h0000_0055);

    // 6. same-cycle read and write to r3
    @(negedge clk);
    rd_we = 1'b1; rd_num = 5'd3; rd_data = 32'd42; rs_num = 5'd3; rt_num = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r3_same_cycle", rs_data, 32'd42);
`else
    check("r3_same_cycle", rs_data, 32'd0);
`endif
    check("r9_other_port", rt_data, 32'h0000_0055);
    @(posedge clk); #1;
    check("r3_after_edge", rs_data, 32'd42);
    @(negedge clk);
    rd_we = 1'b0; rd_data = 32'd7;
    #1;
    check("r3_hold", rs_data, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
